// File: rtl/msrv32_agu_if.sv
// Request/response bundle between decode, the AGU and the branch/LSU consumers.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; the AGU drives in_ready_out and out_valid_out.
// Ports: request side (in_*, pc/rs1/imm, base_sel/op/size), response side
//        (out_valid/out_ready, addr, misaligned), debug counter (clr_cnt_in, misalign_cnt_out).
interface msrv32_agu_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
);
   logic             in_valid_in;
   logic             in_ready_out;
   logic [XLEN-1:0]  pc_in;
   logic [XLEN-1:0]  rs1_in;
   logic [XLEN-1:0]  imm_in;
   logic [1:0]       base_sel_in;
   logic [1:0]       op_in;
   logic [1:0]       size_in;
   logic             out_valid_out;
   logic             out_ready_in;
   logic [XLEN-1:0]  addr_out;
   logic             misaligned_out;
   logic             clr_cnt_in;
   logic [CNT_W-1:0] misalign_cnt_out;

   // AGU side
   modport slave (
      input  in_valid_in, pc_in, rs1_in, imm_in, base_sel_in, op_in, size_in,
             out_ready_in, clr_cnt_in,
      output in_ready_out, out_valid_out, addr_out, misaligned_out, misalign_cnt_out
   );

   // Requester/consumer side
   modport master (
      output in_valid_in, pc_in, rs1_in, imm_in, base_sel_in, op_in, size_in,
             out_ready_in, clr_cnt_in,
      input  in_ready_out, out_valid_out, addr_out, misaligned_out, misalign_cnt_out
   );
endinterface

// File: rtl/msrv32_agu.sv
// Address generation: base (PC/RS1/zero) + imm, JALR bit-0 clear, misalignment flag.
// Latency: 1 cycle from accepted request to out_valid_out via a 2-entry output buffer.
// Backpressure: in_ready_out = buffer not full, from registered count only (no path from out_ready_in).
// Ports: clk_in, rst_n_in (async active-low); bus (slave modport) carries the request,
//        response and misalign-counter signals.
module msrv32_agu #(
   parameter int XLEN   = 32,
   parameter int IALIGN = 32,
   parameter int CNT_W  = 8
) (
   input logic          clk_in,
   input logic          rst_n_in,
   msrv32_agu_if.slave  bus
);
   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            mis;
   } ent_t;

   logic [XLEN-1:0]  base;
   logic [XLEN-1:0]  sum;
   logic [XLEN-1:0]  addr_calc;
   logic             mis_calc;

   ent_t             mem_q [2];
   ent_t             mem_d [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             in_rdy;
   logic             out_vld;
   logic             push;
   logic             pop;

   // Address and alignment check on the incoming request
   always_comb begin
      base = '0;
      case (bus.base_sel_in)
         2'b00:   base = bus.pc_in;
         2'b01:   base = bus.rs1_in;
         default: base = '0;
      endcase

      sum       = base + bus.imm_in;
      addr_calc = sum;
      if (bus.op_in == 2'b01) begin
         addr_calc[0] = 1'b0;
      end

      mis_calc = 1'b0;
      if (bus.op_in[1] == 1'b0) begin
         // fetch / JALR target: size is irrelevant, only instruction alignment matters
         mis_calc = (IALIGN == 16) ? addr_calc[0] : (addr_calc[1:0] != 2'b00);
      end else begin
         case (bus.size_in)
            2'b00:   mis_calc = 1'b0;
            2'b01:   mis_calc = addr_calc[0];
            2'b10:   mis_calc = (addr_calc[1:0] != 2'b00);
            // doubleword on a 32-bit datapath degrades to a word access
            default: mis_calc = (XLEN == 64) ? (addr_calc[2:0] != 3'b000)
                                             : (addr_calc[1:0] != 2'b00);
         endcase
      end
   end

   assign in_rdy  = (count_q != 2'd2);
   assign out_vld = (count_q != 2'd0);
   assign push    = bus.in_valid_in & in_rdy;
   assign pop     = out_vld & bus.out_ready_in;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cnt_d    = cnt_q;

      if (push) begin
         mem_d[wr_ptr_q].addr = addr_calc;
         mem_d[wr_ptr_q].mis  = mis_calc;
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end

      // clear wins over a same-cycle increment
      if (bus.clr_cnt_in) begin
         cnt_d = '0;
      end else if (push && mis_calc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cnt_q    <= cnt_d;
      end
   end

   // Outputs come straight from the head entry so they hold while stalled
   assign bus.in_ready_out     = in_rdy;
   assign bus.out_valid_out    = out_vld;
   assign bus.addr_out         = mem_q[rd_ptr_q].addr;
   assign bus.misaligned_out   = mem_q[rd_ptr_q].mis;
   assign bus.misalign_cnt_out = cnt_q;
endmodule

// File: doc/msrv32_agu.md
# msrv32_agu

Parametrised address-generation unit, successor to the single-cycle immediate adder. It adds a sign-extended immediate to a selected base (PC, RS1 or zero) and handles JALR bit-0 clearing and instruction/data misalignment detection. Results pass through a registered 2-entry skid buffer with valid/ready handshakes, so the unit sits between decode and the branch/LSU stages. A saturating counter tracks misaligned events for debug/perf.

## Interface
- XLEN, 32, datapath width (32 or 64)
- IALIGN, 32, instruction alignment in bits (16 or 32)
- CNT_W, 8, misalign counter width
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- in_valid_in  input  1  request valid
- in_ready_out  output  1  unit can accept a request
- pc_in  input  XLEN  current PC
- rs1_in  input  XLEN  register operand
- imm_in  input  XLEN  immediate, already sign-extended
- base_sel_in  input  2  00 PC, 01 RS1, 10 zero, 11 zero
- op_in  input  2  00 fetch target, 01 JALR target, 10 data access, 11 treated as data access
- size_in  input  2  data size: 00 byte, 01 half, 10 word, 11 doubleword
- out_valid_out  output  1  result valid
- out_ready_in  input  1  consumer accepts result
- addr_out  output  XLEN  computed address
- misaligned_out  output  1  alignment fault for this result
- clr_cnt_in  input  1  synchronous clear of counter
- misalign_cnt_out  output  CNT_W  saturating misaligned-event count

## Operation
- Sum = base + imm_in, modulo 2^XLEN; carry discarded.
- op 01: addr = sum with bit 0 forced to 0; alignment checked after clearing.
- Fetch/JALR misaligned: IALIGN=32 -> addr[1:0]!=0; IALIGN=16 -> addr[0]!=0.
- Data misaligned: byte never; half addr[0]; word addr[1:0]!=0; doubleword addr[2:0]!=0 (size 11 with XLEN=32 treated as word).
- size_in ignored for op 00/01.
- Address and flag are computed combinationally at input and stored into the buffer; the outputs come from the head entry only.
- Buffer: 2 entries, FIFO order, registered occupancy count 0..2.
- in_ready_out = (count < 2), decoded from registered count only, with no combinational path from out_ready_in.
- Push when in_valid_in & in_ready_out; pop when out_valid_out & out_ready_in; simultaneous push and pop keeps count and order.
- out_valid_out = (count != 0).
- Counter increments by 1 on each push with misaligned flag set; saturates at 2^CNT_W-1. clr_cnt_in has priority over increment in the same cycle.

## Timing
- Reset (async assert, sync-safe deassert): count=0, out_valid_out=0, in_ready_out=1, addr_out=0, misaligned_out=0, misalign_cnt_out=0.
- Latency: request accepted at edge N appears on out_valid_out/addr_out after edge N (1 cycle) if buffer was empty.
- Output stable while out_valid_out=1 and out_ready_in=0.
- Full (count=2): in_ready_out=0; pop at edge N raises in_ready_out after N; push is not accepted in the same cycle as the pop.
- Empty with push only: count 0->1; no bypass path to output.
- Reset mid-operation drops all buffered entries and clears the counter immediately.
- Counter counts on push (acceptance), not on pop.

## Test plan
- Reset, then PC=0x1000, imm=0x0000_0010, base 00, op 00 -> one cycle later addr_out=0x1010, misaligned_out=0; misalign_cnt_out=0.
- JALR: rs1=0x2001, imm=0x0000_0004, base 01, op 01, IALIGN=32 -> addr_out=0x2004, misaligned=0. With imm=0x6 -> addr_out=0x2006, misaligned=1, count=1.
- Data: rs1=0x3000, imm=0xFFFF_FFFF (-1), size 10 -> addr_out=0x2FFF, misaligned=1. Same operands with size 00 -> misaligned=0. Wrap case: rs1=0xFFFF_FFFC, imm=8 -> addr_out=0x4.
- Backpressure: hold out_ready_in=0 and push 3 requests -> first two accepted, in_ready_out=0 on the third; release -> outputs appear in order, one per cycle, third then accepted.
- Saturation: CNT_W=2, push 5 misaligned requests -> count 1,2,3,3,3. clr_cnt_in asserted together with a misaligned push -> count=0.
- Assert rst_n_in low with 2 buffered entries -> out_valid_out=0 and count=0 immediately, before the next clock edge.
